// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite pipeline: scanner, store and X matcher.
package sprite_pkg;

    localparam int N_SLOTS   = 10;  // sprite store depth, max hits per line
    localparam int N_ENTRIES = 40;  // OAM entries walked per line
    localparam int Y_OFFSET  = 16;  // bias applied to OAM Y bytes

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        CMP,
        DONE
    } scan_state_t;

    typedef logic [5:0] sprite_index_t;
    typedef logic [3:0] sprite_line_t;

endpackage

// File: rtl/sprite_y_match.sv
// Combinational Y-range test for one OAM entry against the current line.
module sprite_y_match #(
    parameter int Y_OFFSET = 16
) (
    input  logic [7:0] ly_i,
    input  logic [7:0] oam_y_i,
    input  logic       obj_tall_i,
    output logic       hit_o,
    output logic [3:0] line_o
);
    import sprite_pkg::*;

    // Nine bits keep the borrow visible: bit 8 set means the sprite starts
    // below this line (or is too far above), so it cannot match.
    logic [8:0]   diff;
    sprite_line_t row;

    assign diff   = {1'b0, ly_i} + 9'(Y_OFFSET) - {1'b0, oam_y_i};
    assign row    = diff[3:0];
    assign hit_o  = !diff[8] && (diff[7:0] < (obj_tall_i ? 8'd16 : 8'd8));
    assign line_o = row;

endmodule

// File: rtl/sprite_scanner.sv
// Per-line OAM scan: walks every OAM entry, matches Y against the latched line,
// and strobes the first N_SLOTS hits into the sprite store in OAM order.
module sprite_scanner #(
    parameter int N_SLOTS   = sprite_pkg::N_SLOTS,
    parameter int N_ENTRIES = sprite_pkg::N_ENTRIES,
    parameter int Y_OFFSET  = sprite_pkg::Y_OFFSET
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               scan_start,
    input  logic [7:0]         ly,
    input  logic               obj_tall,
    input  logic [7:0]         oam_y,
    output logic [7:0]         oam_a,
    output logic               scanning,
    output logic               scan_done,
    output logic [N_SLOTS-1:0] store_we,
    output logic [5:0]         store_index,
    output logic [3:0]         store_line,
    output logic [3:0]         sprite_count
);
    import sprite_pkg::*;

    scan_state_t        state_q;
    sprite_index_t      index_q;
    logic [7:0]         ly_q;
    logic               tall_q;
    logic [7:0]         oam_a_q;
    logic               scanning_q;
    logic               scan_done_q;
    logic [N_SLOTS-1:0] store_we_q;
    sprite_index_t      store_index_q;
    sprite_line_t       store_line_q;
    logic [3:0]         count_q;

    logic               hit;
    sprite_line_t       row;

    // Match uses the line and height captured at scan start, not the live inputs.
    sprite_y_match #(
        .Y_OFFSET (Y_OFFSET)
    ) u_y_match (
        .ly_i       (ly_q),
        .oam_y_i    (oam_y),
        .obj_tall_i (tall_q),
        .hit_o      (hit),
        .line_o     (row)
    );

    // Scan FSM: two cycles per entry (address, then compare), all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            index_q       <= '0;
            ly_q          <= '0;
            tall_q        <= 1'b0;
            oam_a_q       <= '0;
            scanning_q    <= 1'b0;
            scan_done_q   <= 1'b0;
            store_we_q    <= '0;
            store_index_q <= '0;
            store_line_q  <= '0;
            count_q       <= '0;
        end else begin
            // Strobes are single-cycle unless re-armed below.
            store_we_q  <= '0;
            scan_done_q <= 1'b0;
            if (scan_start) begin
                // Starting also aborts any scan in flight; a compare landing on
                // this same edge belongs to the abandoned scan and is dropped.
                state_q    <= ADDR;
                index_q    <= '0;
                count_q    <= '0;
                ly_q       <= ly;
                tall_q     <= obj_tall;
                oam_a_q    <= '0;
                scanning_q <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: state_q <= IDLE;
                    ADDR: state_q <= CMP;
                    CMP: begin
                        if (hit && (count_q < 4'(N_SLOTS))) begin
                            store_we_q    <= N_SLOTS'(1) << count_q;
                            store_index_q <= index_q;
                            store_line_q  <= row;
                            count_q       <= count_q + 4'd1;
                        end
                        if (index_q < 6'(N_ENTRIES - 1)) begin
                            index_q <= index_q + 6'd1;
                            oam_a_q <= {index_q + 6'd1, 2'b00};
                            state_q <= ADDR;
                        end else begin
                            state_q     <= DONE;
                            scanning_q  <= 1'b0;
                            scan_done_q <= 1'b1;
                        end
                    end
                    DONE: state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign oam_a        = oam_a_q;
    assign scanning     = scanning_q;
    assign scan_done    = scan_done_q;
    assign store_we     = store_we_q;
    assign store_index  = store_index_q;
    assign store_line   = store_line_q;
    assign sprite_count = count_q;

endmodule

// File: tb/tb_sprite_scanner.sv
// Self-checking bench for sprite_scanner: directed cases plus randomized OAM
// contents, compared cycle by cycle against a list-of-hits reference model.
module tb_sprite_scanner;

    localparam int NS = 10;
    localparam int NE = 40;
    localparam int NC = 85;   // cycles observed after each scan_start edge

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          scan_start = 1'b0;
    logic [7:0]    ly = 8'd0;
    logic          obj_tall = 1'b0;
    logic [7:0]    oam_y;
    logic [7:0]    oam_a;
    logic          scanning;
    logic          scan_done;
    logic [NS-1:0] store_we;
    logic [5:0]    store_index;
    logic [3:0]    store_line;
    logic [3:0]    sprite_count;

    logic [7:0]    oam_mem [NE];

    int vectors     = 0;
    int miscompares = 0;

    int exp_we   [NC];
    int exp_idx  [NC];
    int exp_line [NC];
    int exp_cnt  [NC];

    sprite_scanner dut (
        .clk          (clk),
        .reset        (reset),
        .scan_start   (scan_start),
        .ly           (ly),
        .obj_tall     (obj_tall),
        .oam_y        (oam_y),
        .oam_a        (oam_a),
        .scanning     (scanning),
        .scan_done    (scan_done),
        .store_we     (store_we),
        .store_index  (store_index),
        .store_line   (store_line),
        .sprite_count (sprite_count)
    );

    always #5 clk = ~clk;

    // OAM read port: Y byte of the entry addressed on the previous cycle.
    always @(posedge clk) begin
        if (int'(oam_a[7:2]) < NE) oam_y <= oam_mem[oam_a[7:2]];
        else                       oam_y <= 8'hFF;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_zero(input string where);
        check_eq({where, ".oam_a"},        32'(oam_a),        32'd0);
        check_eq({where, ".scanning"},     32'(scanning),     32'd0);
        check_eq({where, ".scan_done"},    32'(scan_done),    32'd0);
        check_eq({where, ".store_we"},     32'(store_we),     32'd0);
        check_eq({where, ".store_index"},  32'(store_index),  32'd0);
        check_eq({where, ".store_line"},   32'(store_line),   32'd0);
        check_eq({where, ".sprite_count"}, 32'(sprite_count), 32'd0);
    endtask

    // Reference: list the first NS entries in OAM order whose row offset
    // (ly + 16 - Y) falls in [0, height); entry i writes in cycle 2i+2.
    task automatic build_model(input logic [7:0] l, input logic t);
        int n;
        int d;
        int h;
        int cnt;
        n = 0;
        h = t ? 16 : 8;
        for (int c = 0; c < NC; c++) begin
            exp_we[c]   = 0;
            exp_idx[c]  = 0;
            exp_line[c] = 0;
        end
        for (int i = 0; i < NE; i++) begin
            d = int'(l) + 16 - int'(oam_mem[i]);
            if (d >= 0 && d < h && n < NS) begin
                exp_we[2*i+2]   = 1 << n;
                exp_idx[2*i+2]  = i;
                exp_line[2*i+2] = d;
                n++;
            end
        end
        cnt = 0;
        for (int c = 0; c < NC; c++) begin
            if (exp_we[c] != 0) cnt++;
            exp_cnt[c] = cnt;
        end
    endtask

    // Pulse scan_start, scramble the live line inputs, then check every cycle.
    task automatic run_scan(input logic [7:0] l, input logic t, input string name);
        build_model(l, t);
        @(negedge clk);
        ly = l; obj_tall = t; scan_start = 1'b1;
        @(negedge clk);
        scan_start = 1'b0;
        ly = 8'($urandom);
        obj_tall = 1'($urandom);
        for (int c = 0; c < NC; c++) begin
            if (c > 0) @(negedge clk);
            check_eq("scanning",     32'(scanning),     32'(c < 80));
            check_eq("scan_done",    32'(scan_done),    32'(c == 80));
            check_eq("store_we",     32'(store_we),     32'(exp_we[c]));
            check_eq("sprite_count", 32'(sprite_count), 32'(exp_cnt[c]));
            if (c < 80) check_eq("oam_a", 32'(oam_a), 32'((c / 2) * 4));
            if (exp_we[c] != 0) begin
                check_eq("store_index", 32'(store_index), 32'(exp_idx[c]));
                check_eq("store_line",  32'(store_line),  32'(exp_line[c]));
            end
        end
        $display("scan %s ly=%0d tall=%0d hits=%0d", name, l, t, exp_cnt[NC-1]);
    endtask

    task automatic fill_oam(input logic [7:0] v);
        for (int i = 0; i < NE; i++) oam_mem[i] = v;
    endtask

    // Mostly near-hit Y values (offsets -2..18) plus some fully random bytes.
    task automatic fill_random(input logic [7:0] l);
        int r;
        for (int i = 0; i < NE; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                oam_mem[i] = 8'($urandom);
            end else begin
                r = int'($urandom_range(0, 20)) - 2;
                oam_mem[i] = 8'(int'(l) + 16 - r);
            end
        end
    endtask

    initial begin
        logic [7:0] rl;
        logic       rt;

        fill_oam(8'd0);
        repeat (3) @(negedge clk);
        check_zero("in_reset");
        reset = 1'b0;
        @(negedge clk);
        check_zero("after_reset");

        // Single hit at entry 0, row 0.
        fill_oam(8'd0); oam_mem[0] = 8'd16;
        run_scan(8'd0, 1'b0, "single");

        // Tall objects: diff 16 misses, diff 15 hits on the last row.
        fill_oam(8'd0); oam_mem[5] = 8'd20;
        run_scan(8'd20, 1'b1, "tall_diff16");
        oam_mem[5] = 8'd21;
        run_scan(8'd20, 1'b1, "tall_diff15");
        run_scan(8'd20, 1'b0, "short_diff15");

        // Every entry hits: only the first NS are stored.
        fill_oam(8'd66);
        run_scan(8'd50, 1'b0, "all_hit");

        // Row 7 hits, row 8 and negative offset miss in 8-line mode.
        fill_oam(8'd0);
        oam_mem[3] = 8'd39; oam_mem[7] = 8'd38; oam_mem[9] = 8'd47;
        run_scan(8'd30, 1'b0, "boundary");

        // Randomized scans.
        for (int k = 0; k < 10; k++) begin
            rl = 8'($urandom);
            rt = 1'($urandom);
            fill_random(rl);
            run_scan(rl, rt, "random");
        end

        // Restart at cycle 30: the first scan has filled the store by then.
        fill_oam(8'd76);
        @(negedge clk);
        ly = 8'd60; obj_tall = 1'b0; scan_start = 1'b1;
        @(negedge clk);
        scan_start = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (c > 0) @(negedge clk);
            check_eq("abort_scan_done", 32'(scan_done), 32'd0);
        end
        run_scan(8'd61, 1'b1, "restart");

        // Asynchronous reset in the middle of cycle 41, then a clean scan.
        fill_oam(8'd76);
        @(negedge clk);
        ly = 8'd60; obj_tall = 1'b0; scan_start = 1'b1;
        @(negedge clk);
        scan_start = 1'b0;
        for (int c = 1; c <= 41; c++) @(negedge clk);
        check_eq("pre_reset_scanning", 32'(scanning), 32'd1);
        #1 reset = 1'b1;
        #1 check_zero("mid_reset");
        @(negedge clk);
        reset = 1'b0;
        check_zero("post_reset");
        run_scan(8'd60, 1'b0, "after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
